// File: rtl/nand_phy_pkg.sv
// nand_phy_pkg: shared state encoding and default timing for the NAND DQS/DQ sequencer
package nand_phy_pkg;
  localparam int DEF_LEN_W = 16;
  localparam int DEF_T_WPRE_CYC = 2;
  localparam int DEF_T_WPST_CYC = 2;
  localparam int DEF_T_RPRE_CYC = 2;
  localparam int DEF_T_RPST_CYC = 2;
  typedef enum logic [2:0] {
    ST_IDLE, ST_WR_PRE, ST_WR_BURST, ST_WR_POST,
    ST_RD_PRE, ST_RD_BURST, ST_RD_POST, ST_FIN
  } nand_dqs_seq_st_t;
  function automatic int max2(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/nand_phy_dqs_timer.sv
// nand_phy_dqs_timer: loadable down-counter that parks at zero
module nand_phy_dqs_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] value,
  output logic         zero
);
  assign zero = value == '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) value <= '0;
    else if (load) value <= load_val;
    else if (!zero) value <= value - W'(1);
endmodule

// File: rtl/nand_phy_dqs_seq.sv
// nand_phy_dqs_seq: per-burst sequencer producing DQS/DQ enables and read capture window
module nand_phy_dqs_seq import nand_phy_pkg::*; #(
  parameter int LEN_W = DEF_LEN_W,
  parameter int T_WPRE_CYC = DEF_T_WPRE_CYC,
  parameter int T_WPST_CYC = DEF_T_WPST_CYC,
  parameter int T_RPRE_CYC = DEF_T_RPRE_CYC,
  parameter int T_RPST_CYC = DEF_T_RPST_CYC
) (
  input  logic             clk0,
  input  logic             rst0_n,
  input  logic             wr_req,
  input  logic             rd_req,
  input  logic [LEN_W-1:0] len,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             dqs_oe_n,
  output logic             dqs_rst_n,
  output logic             dq_oe_n,
  output logic             wr_data_en,
  output logic             rd_win
);
  localparam int TMAX = max2(max2(T_WPRE_CYC, T_WPST_CYC), max2(T_RPRE_CYC, T_RPST_CYC));
  localparam int CW = max2(LEN_W, $clog2(TMAX + 1));
  localparam logic [CW-1:0] WPRE_LV = CW'(T_WPRE_CYC - 1);
  localparam logic [CW-1:0] WPST_LV = CW'(T_WPST_CYC - 1);
  localparam logic [CW-1:0] RPRE_LV = CW'(T_RPRE_CYC - 1);
  localparam logic [CW-1:0] RPST_LV = CW'(T_RPST_CYC - 1);
  nand_dqs_seq_st_t st, nxt;
  logic [LEN_W-1:0] len_q;
  logic [CW-1:0] lv, cnt, blen;
  logic ld, zero, nlast;
  nand_phy_dqs_timer #(.W(CW)) u_timer (
    .clk(clk0), .rst_n(rst0_n), .load(ld), .load_val(lv), .value(cnt), .zero(zero)
  );
  always_comb begin
    nxt = st;
    case (st)
      ST_IDLE:     nxt = !(wr_req || rd_req) ? ST_IDLE : len == '0 ? ST_FIN : wr_req ? ST_WR_PRE : ST_RD_PRE;
      ST_WR_PRE:   nxt = abort ? ST_WR_POST : zero ? ST_WR_BURST : ST_WR_PRE;
      ST_WR_BURST: nxt = abort || zero ? ST_WR_POST : ST_WR_BURST;
      ST_WR_POST:  nxt = zero ? ST_FIN : ST_WR_POST;
      ST_RD_PRE:   nxt = abort ? ST_FIN : zero ? ST_RD_BURST : ST_RD_PRE;
      ST_RD_BURST: nxt = abort ? ST_FIN : zero ? ST_RD_POST : ST_RD_BURST;
      ST_RD_POST:  nxt = abort || zero ? ST_FIN : ST_RD_POST;
      default:     nxt = ST_IDLE;
    endcase
  end
  // every phase change reloads the counter with that phase's length minus one
  assign blen = CW'(len_q) - CW'(1);
  assign ld = nxt != st;
  assign lv = nxt == ST_WR_PRE ? WPRE_LV : nxt == ST_WR_POST ? WPST_LV :
              nxt == ST_RD_PRE ? RPRE_LV : nxt == ST_RD_POST ? RPST_LV :
              nxt inside {ST_WR_BURST, ST_RD_BURST} ? blen : '0;
  // true when the coming cycle is the final one of its phase
  assign nlast = ld ? lv == '0 : cnt == CW'(1);
  always_ff @(posedge clk0 or negedge rst0_n)
    if (!rst0_n) begin
      st <= ST_IDLE;
      len_q <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      dqs_oe_n <= 1'b1;
      dqs_rst_n <= 1'b0;
      dq_oe_n <= 1'b1;
      wr_data_en <= 1'b0;
      rd_win <= 1'b0;
    end else begin
      st <= nxt;
      if (st == ST_IDLE) len_q <= len;
      busy <= nxt != ST_IDLE;
      done <= nxt == ST_FIN;
      dqs_oe_n <= !(nxt inside {ST_WR_PRE, ST_WR_BURST, ST_WR_POST});
      dqs_rst_n <= nxt == ST_WR_BURST;
      dq_oe_n <= !(nxt inside {ST_WR_PRE, ST_WR_BURST});
      wr_data_en <= (nxt == ST_WR_PRE && nlast) || (nxt == ST_WR_BURST && !nlast);
      rd_win <= nxt inside {ST_RD_BURST, ST_RD_POST};
    end
endmodule
